data_unpack: RTL and testbench

- Element unpacker for the SpMV kernel's 64-bit datapath.
- Accepts packed 64-bit words and emits one element per output beat. Element width is selected by ctrl_sig_yi: 16-bit, 32-bit or 64-bit.
- It is the inverse of the Yi packing stage. It sits between the HBM/AXI read stream and the per-element compute lanes.
- Each element is returned right-aligned on a 64-bit bus.

---
 rtl/spmv_pkg.sv | 29 ++
 rtl/data_unpack_if.sv | 24 ++
 rtl/data_unpack_lane_sel.sv | 23 ++
 rtl/data_unpack.sv | 93 +++++++++
 tb/tb_data_unpack.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared SpMV element-width encodings and helpers used by the Yi pack/unpack stages.
package spmv_pkg;

    localparam logic [1:0] YI_W16 = 2'd0;
    localparam logic [1:0] YI_W32 = 2'd1;
    localparam logic [1:0] YI_W64 = 2'd2;

    // Width codes 3..7 are reserved and behave as 64-bit.
    function automatic logic [1:0] norm_mode(input logic [2:0] m);
        return (m > 3'd2) ? YI_W64 : m[1:0];
    endfunction

    function automatic logic [2:0] lanes_of(input logic [1:0] mode);
        case (mode)
            YI_W16:  return 3'd4;
            YI_W32:  return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [63:0] ext_elem(input logic [63:0] d, input logic [1:0] mode, input bit sgn);
        case (mode)
            YI_W16:  return sgn ? {{48{d[15]}}, d[15:0]} : {48'b0, d[15:0]};
            YI_W32:  return sgn ? {{32{d[31]}}, d[31:0]} : {32'b0, d[31:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/data_unpack_if.sv
// Word-in / element-out handshake bundle for the Yi unpacker.
interface data_unpack_if;
    logic [2:0]  ctrl_sig_yi;
    logic        in_valid;
    logic [63:0] in_data;
    logic [2:0]  in_num;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    modport slave (
        input  ctrl_sig_yi, in_valid, in_data, in_num, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output ctrl_sig_yi, in_valid, in_data, in_num, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/data_unpack_lane_sel.sv
// Picks lane idx out of the held word and right-aligns/extends it to 64 bits.
module data_unpack_lane_sel
    import spmv_pkg::*;
#(
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic [63:0] buf_i,
    input  logic [1:0]  mode_i,
    input  logic [1:0]  idx_i,
    output logic [63:0] elem_o
);
    logic [63:0] shifted;

    always_comb begin
        shifted = buf_i;
        case (mode_i)
            YI_W16:  shifted = buf_i >> {idx_i, 4'b0000};
            YI_W32:  shifted = buf_i >> {idx_i[0], 5'b00000};
            default: shifted = buf_i;
        endcase
        elem_o = ext_elem(shifted, mode_i, SIGN_EXT);
    end
endmodule

// File: rtl/data_unpack.sv
// Yi element unpacker: holds one packed 64-bit word and streams its elements one per beat.
module data_unpack
    import spmv_pkg::*;
#(
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    data_unpack_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  rem_q, rem_d;
    logic        lastf_q, lastf_d;

    logic [1:0]  mode_in;
    logic [2:0]  lanes_in, eff_in;
    logic        in_ready, accept, elem_hs, final_elem;
    logic [63:0] elem;

    assign mode_in  = norm_mode(bus.ctrl_sig_yi);
    assign lanes_in = lanes_of(mode_in);
    assign eff_in   = (bus.in_num == 3'd0 || bus.in_num > lanes_in) ? lanes_in : bus.in_num;

    // Refill in the same cycle the final element leaves; this path is combinational on out_ready.
    assign final_elem = (state_q == EMIT) && (rem_q == 3'd1);
    assign in_ready   = (state_q == IDLE) || (final_elem && bus.out_ready);
    assign accept     = bus.in_valid && in_ready;
    assign elem_hs    = (state_q == EMIT) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        lastf_d = lastf_q;
        if (elem_hs) begin
            if (rem_q > 3'd1) begin
                idx_d = idx_q + 2'd1;
                rem_d = rem_q - 3'd1;
            end else begin
                state_d = IDLE;
            end
        end
        if (accept) begin
            state_d = EMIT;
            buf_d   = bus.in_data;
            mode_d  = mode_in;
            idx_d   = 2'd0;
            rem_d   = eff_in;
            lastf_d = bus.in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= YI_W16;
            idx_q   <= 2'd0;
            rem_q   <= 3'd0;
            lastf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            lastf_q <= lastf_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    data_unpack_lane_sel #(.SIGN_EXT(SIGN_EXT)) u_lane_sel (
        .buf_i  (buf_q),
        .mode_i (mode_q),
        .idx_i  (idx_q),
        .elem_o (elem)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = elem;
    assign bus.out_last  = final_elem && lastf_q;
    assign bus.busy      = (state_q == EMIT);
endmodule

// File: tb/tb_data_unpack.sv
// Directed bench: zero-extend and sign-extend unpackers driven by identical stimulus.
module tb_data_unpack;
    logic        clk;
    logic        rstn;
    logic [2:0]  ctrl;
    logic        in_valid;
    logic [63:0] in_data;
    logic [2:0]  in_num;
    logic        in_last;
    logic        out_ready;

    int checks;
    int failures;

    data_unpack_if if0 ();
    data_unpack_if if1 ();

    assign if0.ctrl_sig_yi = ctrl;
    assign if0.in_valid    = in_valid;
    assign if0.in_data     = in_data;
    assign if0.in_num      = in_num;
    assign if0.in_last     = in_last;
    assign if0.out_ready   = out_ready;
    assign if1.ctrl_sig_yi = ctrl;
    assign if1.in_valid    = in_valid;
    assign if1.in_data     = in_data;
    assign if1.in_num      = in_num;
    assign if1.in_last     = in_last;
    assign if1.out_ready   = out_ready;

    data_unpack #(.SIGN_EXT(1'b0)) dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    data_unpack #(.SIGN_EXT(1'b1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word; the accept happens on the next rising edge.
    task automatic send(input logic [2:0] c, input logic [63:0] d, input logic [2:0] n, input logic l);
        ctrl     = c;
        in_data  = d;
        in_num   = n;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_in_ready", {63'b0, if0.in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [63:0] exp0, input logic exp_last, input logic exp_rdy);
        @(negedge clk);
        chk({tag, "_valid"}, {63'b0, if0.out_valid}, 64'd1);
        chk({tag, "_data"},  if0.out_data, exp0);
        chk({tag, "_last"},  {63'b0, if0.out_last}, {63'b0, exp_last});
        chk({tag, "_ready"}, {63'b0, if0.in_ready}, {63'b0, exp_rdy});
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, {63'b0, if0.out_valid}, 64'd0);
        chk({tag, "_busy"},  {63'b0, if0.busy}, 64'd0);
        chk({tag, "_ready"}, {63'b0, if0.in_ready}, 64'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        rstn = 1'b0; ctrl = 3'd0; in_valid = 1'b0; in_data = '0;
        in_num = 3'd0; in_last = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_valid", {63'b0, if0.out_valid}, 64'd0);
        chk("rst_last",  {63'b0, if0.out_last}, 64'd0);
        chk("rst_busy",  {63'b0, if0.busy}, 64'd0);
        chk("rst_ready", {63'b0, if0.in_ready}, 64'd1);
        tick();

        // 16b full word: four beats, refill window only on the last.
        send(3'd0, 64'h4444_3333_2222_1111, 3'd0, 1'b0);
        beat("w16_b0", 64'h1111, 1'b0, 1'b0); tick();
        beat("w16_b1", 64'h2222, 1'b0, 1'b0); tick();
        beat("w16_b2", 64'h3333, 1'b0, 1'b0); tick();
        beat("w16_b3", 64'h4444, 1'b0, 1'b1); tick();
        idle_chk("w16_done");
        tick();

        // 32b word with last: sign vs zero extension of the upper lane.
        send(3'd1, 64'h8000_0001_7FFF_FFFF, 3'd0, 1'b1);
        beat("w32_b0", 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0);
        chk("w32_b0_sx", if1.out_data, 64'h0000_0000_7FFF_FFFF);
        tick();
        beat("w32_b1", 64'h0000_0000_8000_0001, 1'b1, 1'b1);
        chk("w32_b1_sx", if1.out_data, 64'hFFFF_FFFF_8000_0001);
        chk("w32_b1_sx_last", {63'b0, if1.out_last}, 64'd1);
        tick();
        idle_chk("w32_done");
        tick();

        // Back-to-back 64b words, one presented every cycle.
        ctrl = 3'd2; in_num = 3'd0; in_last = 1'b0; in_valid = 1'b1;
        in_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("b2b_ready0", {63'b0, if0.in_ready}, 64'd1);
        tick();
        in_data = 64'hFEDC_BA98_7654_3210;
        beat("b2b_o0", 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1); tick();
        in_data = 64'h8000_0000_0000_0001; in_last = 1'b1;
        beat("b2b_o1", 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1); tick();
        in_valid = 1'b0; in_last = 1'b0;
        beat("b2b_o2", 64'h8000_0000_0000_0001, 1'b1, 1'b1); tick();
        idle_chk("b2b_done");
        tick();

        // Partial 16b word (3 lanes) with backpressure 1,0,0,1,1.
        send(3'd0, 64'hDDDD_CCCC_BBBB_AAAA, 3'd3, 1'b0);
        out_ready = 1'b1;
        beat("part_b0", 64'hAAAA, 1'b0, 1'b0);
        chk("part_b0_sx", if1.out_data, 64'hFFFF_FFFF_FFFF_AAAA);
        tick();
        out_ready = 1'b0;
        beat("part_stall0", 64'hBBBB, 1'b0, 1'b0); tick();
        beat("part_stall1", 64'hBBBB, 1'b0, 1'b0); tick();
        out_ready = 1'b1;
        beat("part_b1", 64'hBBBB, 1'b0, 1'b0); tick();
        beat("part_b2", 64'hCCCC, 1'b0, 1'b1); tick();
        idle_chk("part_done");
        tick();

        // Width control changes after accept; held word stays 16b.
        send(3'd0, 64'h9004_0003_0002_0001, 3'd0, 1'b0);
        ctrl = 3'd2;
        beat("mchg_b0", 64'h0001, 1'b0, 1'b0); tick();
        beat("mchg_b1", 64'h0002, 1'b0, 1'b0); tick();
        beat("mchg_b2", 64'h0003, 1'b0, 1'b0); tick();
        beat("mchg_b3", 64'h9004, 1'b0, 1'b1);
        chk("mchg_b3_sx", if1.out_data, 64'hFFFF_FFFF_FFFF_9004);
        tick();
        idle_chk("mchg_done");
        tick();

        // Reserved width code acts as 64b; in_num above lane count clamps to one element.
        send(3'd6, 64'h1122_3344_5566_7788, 3'd4, 1'b0);
        beat("rsv_b0", 64'h1122_3344_5566_7788, 1'b0, 1'b1); tick();
        idle_chk("rsv_done");
        tick();

        // Reset after the second 16b element drops the held word.
        send(3'd0, 64'h4444_3333_2222_1111, 3'd0, 1'b0);
        beat("rst_b0", 64'h1111, 1'b0, 1'b0); tick();
        beat("rst_b1", 64'h2222, 1'b0, 1'b0); tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        idle_chk("rst_emit");
        tick();
        idle_chk("rst_stay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
